// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and the
// all-ones quotient returned on divide-by-zero (slice it to the datapath width).
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest datapath the divide-by-zero constant can serve.
  localparam int unsigned MAX_WIDTH = 64;

  // Divide-by-zero quotient; use DIV_ZERO_QUOTIENT[WIDTH-1:0].
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/restoring_divider_sub_nbit.sv
// N-bit subtractor a - b computed as a + ~b + 1 using 4-bit carry-lookahead
// slices chained by carry. The final carry-out is the not-borrow flag (a >= b).
// Ports:
//   a_i         minuend
//   b_i         subtrahend
//   diff_o      a - b modulo 2^N
//   no_borrow_o carry-out of the chain
module restoring_divider_sub_nbit #(
  parameter int unsigned N = 17
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         no_borrow_o
);

  localparam int unsigned NSL = (N + 3) / 4;
  localparam int unsigned PW  = NSL * 4;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_inv;
  logic [PW-1:0] g;
  logic [PW-1:0] p;
  logic [NSL:0]  carry;
  logic [N-1:0]  c_bit;

  // Zero padding above bit N-1 passes the slice carry straight through.
  assign a_ext    = PW'(a_i);
  assign b_inv    = ~(PW'(b_i));
  assign g        = a_ext & b_inv;
  assign p        = a_ext ^ b_inv;
  assign carry[0] = 1'b1;

  for (genvar s = 0; s < NSL; s++) begin : g_slice
    localparam int unsigned B = 4 * s;

    // Group carry-out of this slice.
    assign carry[s+1] = g[B+3]
                      | (p[B+3] & g[B+2])
                      | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & carry[s]);

    // Per-bit lookahead carries, only for bits that reach the result.
    for (genvar j = 0; j < 4; j++) begin : g_bit
      if (B + j < N) begin : g_used
        if (j == 0) begin : g_c0
          assign c_bit[B] = carry[s];
        end else if (j == 1) begin : g_c1
          assign c_bit[B+1] = g[B] | (p[B] & carry[s]);
        end else if (j == 2) begin : g_c2
          assign c_bit[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & carry[s]);
        end else begin : g_c3
          assign c_bit[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                            | (p[B+2] & p[B+1] & p[B] & carry[s]);
        end
      end
    end
  end

  assign diff_o      = p[N-1:0] ^ c_bit;
  assign no_borrow_o = carry[NSL];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, start/busy/done
// handshake, results held until the next accepted start.
// Optional feature: define DIVIDER_SIGNED_EN for two's-complement operands
// (truncating division; sign fix-up folded into the DONE register load).
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               request, accepted whenever not busy
//   dividend_i/divisor_i  operands, sampled with an accepted start
//   busy_o                high while iterating
//   done_o                one-cycle pulse when results are valid
//   quotient_o/remainder_o results; div_by_zero_o flags a zero divisor
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = WIDTH + 1;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("restoring_divider: WIDTH must be a multiple of 4 in [4, MAX_WIDTH]");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2*WIDTH:0] pair_shift;
  logic [RW-1:0]    r_shift;
  logic [RW-1:0]    sub_diff;
  logic             no_borrow;
  logic [RW-1:0]    iter_rem;
  logic [WIDTH-1:0] iter_quo;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             accept;

  // One iteration: shift {remainder, dividend/quotient} left, trial subtract.
  assign pair_shift = {rem_q, shreg_q} << 1;
  assign r_shift    = pair_shift[2*WIDTH:WIDTH];

  restoring_divider_sub_nbit #(
    .N (RW)
  ) u_sub_nbit (
    .a_i         (r_shift),
    .b_i         ({1'b0, divisor_q}),
    .diff_o      (sub_diff),
    .no_borrow_o (no_borrow)
  );

  assign iter_rem = no_borrow ? sub_diff : r_shift;
  assign iter_quo = pair_shift[WIDTH-1:0] | WIDTH'(no_borrow);
  assign accept   = start_i && (state_q != ST_RUN);

`ifdef DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  // Iterate on magnitudes; most-negative maps onto itself as an unsigned value.
  assign dvd_mag  = dividend_i[WIDTH-1] ? (WIDTH'(0) - dividend_i) : dividend_i;
  assign dvs_mag  = divisor_i[WIDTH-1]  ? (WIDTH'(0) - divisor_i)  : divisor_i;
  assign quot_fix = neg_quo_q ? (WIDTH'(0) - iter_quo) : iter_quo;
  assign rem_fix  = neg_rem_q ? (WIDTH'(0) - iter_rem[WIDTH-1:0]) : iter_rem[WIDTH-1:0];
`else
  assign dvd_mag  = dividend_i;
  assign dvs_mag  = divisor_i;
  assign quot_fix = iter_quo;
  assign rem_fix  = iter_rem[WIDTH-1:0];
`endif

  // Next-state and register-load logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    shreg_d   = shreg_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif

    case (state_q)
      ST_RUN: begin
        rem_d   = iter_rem;
        shreg_d = iter_quo;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = ST_DONE;
          quot_d  = quot_fix;
          remo_d  = rem_fix;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    // Accept overrides the IDLE hold and the DONE->IDLE return.
    if (accept) begin
      rem_d     = '0;
      shreg_d   = dvd_mag;
      divisor_d = dvs_mag;
      count_d   = CW'(WIDTH);
      dbz_d     = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_rem_d = dividend_i[WIDTH-1];
`endif
      if (divisor_i == '0) begin
        state_d = ST_DONE;
        quot_d  = DIV_ZERO_QUOTIENT[WIDTH-1:0];
        remo_d  = dividend_i;
        dbz_d   = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      shreg_q   <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      remo_q    <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      shreg_q   <= shreg_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      remo_q    <= remo_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quot_q;
  assign remainder_o   = remo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: the driver pushes reference results
// (plain arithmetic) with their expected done cycle; a negedge monitor pops
// and compares on every done pulse.
module tb_restoring_divider;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  restoring_divider #(.WIDTH(W)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_cyc;
    string        tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   busy_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: floor division / modulo, or truncating signed division.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
`ifdef DIVIDER_SIGNED_EN
    int sa;
    int sb;
`endif
    e.done_cyc = 0;
    e.tag      = "";
    if (b == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      busy_run = 0;
    end else if (done) begin
      n_done++;
      chk("busy_done_exclusive", 32'(busy), 32'(0));
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: done with no outstanding request, q=0x%0h (cycle %0d)",
                 quotient, cyc);
      end else begin
        e = sb_q.pop_front();
        chk({e.tag, "_quotient"},  32'(quotient),    32'(e.q));
        chk({e.tag, "_remainder"}, 32'(remainder),   32'(e.r));
        chk({e.tag, "_dbz"},       32'(div_by_zero), 32'(e.dbz));
        chk({e.tag, "_done_cycle"}, 32'(cyc),        32'(e.done_cyc));
        chk({e.tag, "_busy_cycles"}, 32'(busy_run),  e.dbz ? 32'(0) : 32'(W));
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Issue one request at the current negedge and walk to its done cycle.
  // keep holds start high (ignored while busy, chains at done); pulse_at
  // injects a 9/3 start pulse mid-run that must be ignored.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit keep, input int pulse_at, input string tag);
    exp_t e;
    int   lat;
    lat        = (b == 0) ? 1 : W + 1;
    e          = model(a, b);
    e.done_cyc = cyc + lat;
    e.tag      = tag;
    start      = 1'b1;
    dividend   = a;
    divisor    = b;
    sb_q.push_back(e);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == pulse_at) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
      end else begin
        start = keep;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      32'(busy),        32'(0));
    chk({tag, "_done"},      32'(done),        32'(0));
    chk({tag, "_quotient"},  32'(quotient),    32'(0));
    chk({tag, "_remainder"}, 32'(remainder),   32'(0));
    chk({tag, "_dbz"},       32'(div_by_zero), 32'(0));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int snap;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit chain;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op(16'd100,   16'd7,  1'b0, 0, "d100_7");
    do_op(16'hFFFF,  16'd1,  1'b0, 0, "dffff_1");
    do_op(16'd3,     16'd10, 1'b0, 0, "d3_10");
    @(negedge clk);
    do_op(16'd5,     16'd0,  1'b0, 0, "d5_0");
    repeat (2) @(negedge clk);
    do_op(16'd100,   16'd7,  1'b0, 5, "ignore_pulse");
    start = 1'b0;
    @(negedge clk);

    // Back-to-back with start held high, including a divide-by-zero link.
    do_op(16'd200,   16'd9,  1'b1, 0, "b2b_a");
    do_op(16'd5,     16'd0,  1'b1, 0, "b2b_dbz");
    do_op(16'd1000,  16'd33, 1'b0, 0, "b2b_c");
    @(negedge clk);

    // Reset in the middle of an operation.
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    snap  = n_done;
    repeat (25) @(negedge clk);
    chk("no_done_after_reset", 32'(n_done), 32'(snap));
    do_op(16'd50, 16'd5, 1'b0, 0, "d50_5");
    @(negedge clk);

`ifdef DIVIDER_SIGNED_EN
    do_op(16'hFFF9, 16'd2,    1'b0, 0, "s_m7_2");
    do_op(16'd7,    16'hFFFE, 1'b0, 0, "s_7_m2");
    do_op(16'h8000, 16'hFFFF, 1'b0, 0, "s_min_m1");
    do_op(16'hFFF9, 16'd0,    1'b0, 0, "s_m7_0");
    @(negedge clk);
`endif

    // Randomized traffic with occasional chaining and idle gaps.
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      a   = 16'($urandom);
      if (sel == 0) begin
        b = '0;
      end else if (sel <= 3) begin
        b = 16'($urandom_range(1, 15));
      end else if (sel <= 6) begin
        b = 16'($urandom);
      end else begin
        a = 16'($urandom_range(0, 200));
        b = 16'($urandom_range(201, 1000));
      end
      chain = ($urandom_range(0, 2) == 0);
      do_op(a, b, chain, 0, "rand");
      if (!chain) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start = 1'b0;

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_queue", 32'(sb_q.size()), 32'(0));
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Multi-cycle unsigned integer divider for the unpipelined processor datapath. It divides by repeated shift-and-subtract, producing one quotient bit per cycle. It sits beside the ALU and is driven by a start/busy/done handshake from the control unit. Its subtract stage is the complement of the carry-lookahead adder: a + ~b + 1, with the carry-out used as the not-borrow flag.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when not busy
- dividend  in  WIDTH  numerator; sampled with an accepted start
- divisor  in  WIDTH  denominator; sampled with an accepted start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse when results are valid
- quotient  out  WIDTH  result; held until the next accepted start
- remainder  out  WIDTH  result; held until the next accepted start
- div_by_zero  out  1  flag for the last operation; held with the results

## Operation
- States:
  - IDLE: initial state.
  - RUN: WIDTH iterations.
  - DONE: one cycle.
- IDLE/DONE with start=1:
  - Latch the operands.
  - Clear the partial remainder (WIDTH+1 bits).
  - Load the shift register with dividend.
  - Set count=WIDTH and clear div_by_zero.
  - If divisor==0: go to DONE, with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Otherwise: go to RUN.
- RUN, each cycle:
  - r' = {r[WIDTH-1:0], msb of shift reg}; shift the shift reg left.
  - d = r' - {0,divisor}, computed in WIDTH+1 bits.
  - If no borrow: r=d and shift in a quotient bit of 1.
  - Else: r=r' and shift in 0.
  - Decrement count; on the cycle count reaches 1, go to DONE.
- DONE:
  - done=1, and quotient/remainder are driven from the final registers.
  - Next state is IDLE, or RUN/DONE if start=1 (back-to-back accepted).
- start while busy=1: ignored; operands are not resampled.
- Results equal floor(dividend/divisor) and dividend mod divisor for all unsigned inputs, including divisor > dividend (q=0, r=dividend).

## Timing
- Reset: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- Reset mid-RUN aborts the operation; no done pulse follows.
- Start accepted at edge k:
  - busy=1 from cycle k+1 through k+WIDTH.
  - done=1 in cycle k+WIDTH+1 (latency WIDTH+1).
- Divide-by-zero: done=1 in cycle k+1 and busy stays 0.
- busy and done are never high together.
- Outputs are registered; there is no combinational input-to-output path.
- Throughput: one divide per WIDTH+1 cycles when start is held high.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - Operands are two's complement.
  - At accept, magnitudes are taken and the result signs are recorded.
  - In DONE, the quotient is negated if the operand signs differ; the remainder takes the dividend's sign (truncation toward zero).
  - The most-negative/−1 case returns quotient=most-negative, remainder=0.
  - Divide-by-zero returns quotient={WIDTH{1}}, remainder=dividend.
  - Latency is unchanged (sign fix-up happens in the DONE register load).
- Undefined: unsigned only; no sign logic is synthesized.

## Structure
- Shared package holds:
  - the state encoding (IDLE, RUN, DONE);
  - DIV_ZERO_QUOTIENT (all ones) as a width-generic constant.
- Sub-module sub_nbit: WIDTH+1-bit subtractor built from 4-bit carry-lookahead slices chained by carry. Inputs a, b; outputs diff and no_borrow (the carry-out). Instantiated once.
- Counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=16, 100/7 -> quotient=14, remainder=2, div_by_zero=0; done exactly 17 cycles after start accepted; busy high for 16 cycles.
- 0xFFFF/1 -> q=0xFFFF, r=0; 3/10 -> q=0, r=3.
- 5/0 -> done 1 cycle after accept, q=0xFFFF, r=5, div_by_zero=1, busy never high.
- Accept 100/7, pulse start with 9/3 at iteration 5 -> second request ignored, result 14/2; hold start high through DONE -> next operation starts with no IDLE cycle.
- reset at iteration 8 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh 50/5 gives q=10, r=0.
- DIVIDER_SIGNED_EN: -7/2 -> q=0xFFFD, r=0xFFFF; 7/-2 -> q=0xFFFD, r=1; 0x8000/0xFFFF -> q=0x8000, r=0.
